// File: rtl/core_pkg.sv
// Shared constants for the core datapath: special register indices,
// APSR flag bit positions and the link register reset pattern.
package core_pkg;
  localparam int SP_IDX_DEF = 13;
  localparam int LR_IDX_DEF = 14;
  localparam int PC_IDX_DEF = 15;

  localparam int APSR_N = 3;
  localparam int APSR_Z = 2;
  localparam int APSR_C = 1;
  localparam int APSR_V = 0;

  // Wide enough for any DATA_W up to 64; the register bank takes the low slice.
  localparam logic [63:0] LR_RESET = '1;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one bit per register, set by load issue, cleared by
// writeback, and a read-after-write hazard reduction over the checked read ports.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int RD_PORTS = 3,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RD_PORTS*AW-1:0] rd_addr,
  input  logic [RD_PORTS-1:0]    rd_check,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic                   ld_issue,
  input  logic [AW-1:0]          ld_addr,
  output logic                   hazard
);
  logic [NUM_REGS-1:0] pend, set_v, clr_v;
  logic [RD_PORTS-1:0] hit;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (ld_issue) set_v[ld_addr] = 1'b1;
    if (wb_en)    clr_v[wb_addr] = 1'b1;
  end

  // Set applied after clear: a new load to the same register stays pending.
  always_ff @(posedge clk or posedge rst)
    if (rst) pend <= '0;
    else     pend <= (pend & ~clr_v) | set_v;

  // Without bypass the writeback data is not visible yet, so the hazard holds.
  for (genvar k = 0; k < RD_PORTS; k++) begin : g_port
    logic [AW-1:0] a;
    assign a      = rd_addr[k*AW +: AW];
    assign hit[k] = rd_check[k] & pend[a] & ~((BYPASS != 0) & wb_en & (wb_addr == a));
  end

  assign hazard = |hit;
endmodule

// File: rtl/core_reg_bank.sv
// Core register bank: GPRs, banked MSP/PSP, LR, PC and status registers with
// two write ports, RD_PORTS combinational read ports and optional write bypass.
module core_reg_bank
  import core_pkg::*;
#(
  parameter int DATA_W                = 32,
  parameter int NUM_REGS              = 16,
  parameter int RD_PORTS              = 3,
  parameter int SP_IDX                = SP_IDX_DEF,
  parameter int LR_IDX                = LR_IDX_DEF,
  parameter int PC_IDX                = PC_IDX_DEF,
  parameter int PC_STEP               = 2,
  parameter logic [DATA_W-1:0] SP_RESET = '0,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter int BYPASS                = 1,
  localparam int AW                   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RD_PORTS*AW-1:0]     rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  input  logic [RD_PORTS-1:0]        rd_check,
  input  logic                       wa_en,
  input  logic [AW-1:0]              wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [AW-1:0]              wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       ld_issue,
  input  logic [AW-1:0]              ld_addr,
  output logic                       hazard,
  input  logic                       pc_inc,
  input  logic                       pc_load,
  input  logic [DATA_W-1:0]          pc_wdata,
  input  logic                       spsel,
  input  logic                       apsr_we,
  input  logic [3:0]                 apsr_wdata,
  input  logic                       ipsr_we,
  input  logic [5:0]                 ipsr_wdata,
  input  logic                       primask_we,
  input  logic                       primask_wdata,
  output logic [DATA_W-1:0]          pc,
  output logic [DATA_W-1:0]          sp,
  output logic [DATA_W-1:0]          lr,
  output logic [3:0]                 apsr,
  output logic [5:0]                 ipsr,
  output logic                       primask
);
  localparam logic [AW-1:0] SP_A = AW'(SP_IDX);
  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] msp, psp, pc_q, sp_act;
  logic              sp_wr;
  logic [DATA_W-1:0] sp_wdata;

  assign sp_act = spsel ? psp : msp;

  // Port B beats port A on a shared destination.
  always_comb begin
    sp_wr    = 1'b0;
    sp_wdata = wa_data;
    if (wb_en && wb_addr == SP_A) begin
      sp_wr    = 1'b1;
      sp_wdata = wb_data;
    end else if (wa_en && wa_addr == SP_A) begin
      sp_wr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= (i == LR_IDX) ? LR_RESET[DATA_W-1:0] : '0;
      msp     <= SP_RESET;
      psp     <= '0;
      pc_q    <= PC_RESET;
      apsr    <= '0;
      ipsr    <= '0;
      primask <= 1'b0;
    end else begin
      // SP and PC slots in the array are shadows; their live state is below.
      for (int i = 0; i < NUM_REGS; i++)
        if (i != SP_IDX && i != PC_IDX) begin
          if (wb_en && wb_addr == AW'(i))      regs[i] <= wb_data;
          else if (wa_en && wa_addr == AW'(i)) regs[i] <= wa_data;
        end
      if (sp_wr) begin
        if (spsel) psp <= sp_wdata;
        else       msp <= sp_wdata;
      end
      if (pc_load)                       pc_q <= pc_wdata;
      else if (wb_en && wb_addr == PC_A) pc_q <= wb_data;
      else if (wa_en && wa_addr == PC_A) pc_q <= wa_data;
      else if (pc_inc)                   pc_q <= pc_q + DATA_W'(PC_STEP);
      if (apsr_we)    apsr    <= apsr_wdata;
      if (ipsr_we)    ipsr    <= ipsr_wdata;
      if (primask_we) primask <= primask_wdata;
    end

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    assign a = rd_addr[k*AW +: AW];
    always_comb begin
      d = regs[a];
      if (a == PC_A)                                 d = pc_q;
      else if (BYPASS != 0 && wb_en && wb_addr == a) d = wb_data;
      else if (BYPASS != 0 && wa_en && wa_addr == a) d = wa_data;
      else if (a == SP_A)                            d = sp_act;
    end
    assign rd_data[k*DATA_W +: DATA_W] = d;
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .RD_PORTS (RD_PORTS),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_check (rd_check),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .ld_issue (ld_issue),
    .ld_addr  (ld_addr),
    .hazard   (hazard)
  );

  assign pc = pc_q;
  assign sp = sp_act;
  assign lr = regs[LR_IDX];
endmodule
